case_conv_stream: RTL and testbench

Streaming ASCII case converter, the parametrised successor to our combinational single-byte uppercase block. It processes LANES bytes per beat and supports four modes: pass, upper, lower and toggle. Letters are detected by exact range check, not by bit pattern. Input and output use a valid/ready handshake with a DEPTH-entry output buffer, and the block keeps a saturating count of bytes it actually modified. It sits between a byte-stream source (UART or memory reader) and downstream text consumers.

---
 rtl/case_conv_stream.sv | 135 +++++++++++++
 tb/tb_case_conv_stream.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/case_conv_stream.sv
// case_conv_stream: streaming ASCII case converter, LANES bytes per beat.
//
// Each byte is converted independently according to mode (00 pass,
// 01 upper, 10 lower, 11 toggle) using exact letter range checks. The
// converted beat and its last flag are written into a DEPTH-entry FIFO on
// accept. A saturating counter tracks how many bytes were modified.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   mode              conversion mode, sampled on accept
//   in_valid/in_ready input handshake; in_ready depends on occupancy only
//   in_data/in_last   input beat (lane k = bits [8k+7:8k]) and end marker
//   out_valid/out_ready output handshake
//   out_data/out_last converted beat and its end marker (registered)
//   cnt_clr           synchronous clear of conv_count
//   conv_count        saturating count of modified bytes
module case_conv_stream #(
    parameter int LANES = 4,
    parameter int DEPTH = 2,
    parameter int CW    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic                 out_last,
    input  logic                 cnt_clr,
    output logic [CW-1:0]        conv_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int NW = $clog2(LANES + 1);
    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

    logic [8*LANES-1:0] conv_data;
    logic [NW-1:0]      n_changed;

    always_comb begin : convert
        logic [7:0] b;
        b         = '0;
        conv_data = in_data;
        n_changed = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            b = in_data[8*k +: 8];
            if (mode[0] && b >= 8'h61 && b <= 8'h7A)
                conv_data[8*k +: 8] = b - 8'h20;
            else if (mode[1] && b >= 8'h41 && b <= 8'h5A)
                conv_data[8*k +: 8] = b + 8'h20;
            if (conv_data[8*k +: 8] != b)
                n_changed = n_changed + NW'(1);
        end
    end

    logic [8*LANES-1:0] mem_data [DEPTH];
    logic               mem_last [DEPTH];
    logic [AW-1:0]      rptr, wptr, rptr_n;
    logic [AW:0]        occ, occ_n;
    logic               accept, drain;
    logic [8*LANES-1:0] head_data_n;
    logic               head_last_n;

    assign in_ready = (occ < DEPTH_V);
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    // The output register is loaded with whatever will be at the head after
    // this edge. A beat written into an empty (or just-emptied) buffer is
    // both the write target and the new head, so bypass the memory for it.
    always_comb begin
        rptr_n      = drain ? rptr + AW'(1) : rptr;
        occ_n       = occ + (AW + 1)'(accept) - (AW + 1)'(drain);
        head_data_n = mem_data[rptr_n];
        head_last_n = mem_last[rptr_n];
        if (accept && (wptr == rptr_n)) begin
            head_data_n = conv_data;
            head_last_n = in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_data[wptr] <= conv_data;
            mem_last[wptr] <= in_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr      <= '0;
            wptr      <= '0;
            occ       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            rptr      <= rptr_n;
            occ       <= occ_n;
            out_valid <= (occ_n != '0);
            if (accept)
                wptr <= wptr + AW'(1);
            if (occ_n != '0) begin
                out_data <= head_data_n;
                out_last <= head_last_n;
            end
        end
    end

    // Sum is widened by NW bits so any overflow is visible before saturating.
    logic [CW+NW-1:0] cnt_sum;

    always_comb begin
        cnt_sum = {{NW{1'b0}}, (cnt_clr ? {CW{1'b0}} : conv_count)}
                + {{CW{1'b0}}, n_changed};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_count <= '0;
        end else if (accept) begin
            if (|cnt_sum[CW+NW-1:CW])
                conv_count <= '1;
            else
                conv_count <= cnt_sum[CW-1:0];
        end else if (cnt_clr) begin
            conv_count <= '0;
        end
    end

endmodule

// File: tb/tb_case_conv_stream.sv
module tb_case_conv_stream;

    localparam int LANES = 4;
    localparam int DEPTH = 2;
    localparam int CW    = 4;
    localparam int CMAX  = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        cnt_clr;
    logic [3:0]  conv_count;

    case_conv_stream #(.LANES(LANES), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .cnt_clr(cnt_clr), .conv_count(conv_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a queue of expected output beats plus a count.
    logic [31:0] q_data [$];
    logic        q_last [$];
    logic [31:0] m_hold_data;
    logic        m_hold_last;
    int          m_count;

    function automatic logic [7:0] conv_byte(input logic [7:0] b, input logic [1:0] m);
        int v;
        v = int'(b);
        if ((m == 2'd1 || m == 2'd3) && v >= 97 && v <= 122) return 8'(v - 32);
        if ((m == 2'd2 || m == 2'd3) && v >= 65 && v <= 90)  return 8'(v + 32);
        return b;
    endfunction

    function automatic logic [31:0] conv_beat(input logic [31:0] d, input logic [1:0] m);
        logic [31:0] r;
        for (int k = 0; k < LANES; k++) r[8*k +: 8] = conv_byte(d[8*k +: 8], m);
        return r;
    endfunction

    function automatic int n_diff(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        for (int k = 0; k < LANES; k++) if (a[8*k +: 8] != b[8*k +: 8]) n++;
        return n;
    endfunction

    function automatic logic [7:0] rand_byte();
        logic [7:0] edges [10];
        edges = '{8'h40, 8'h5B, 8'h60, 8'h7B, 8'h80, 8'hFF, 8'h41, 8'h5A, 8'h61, 8'h7A};
        case ($urandom_range(0, 3))
            0:       return 8'($urandom_range(0, 255));
            1:       return 8'(8'h41 + $urandom_range(0, 25));
            2:       return 8'(8'h61 + $urandom_range(0, 25));
            default: return edges[$urandom_range(0, 9)];
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_data.delete();
        q_last.delete();
        m_hold_data = '0;
        m_hold_last = 1'b0;
        m_count     = 0;
    endtask

    task automatic check_all();
        chk("in_ready",   32'(in_ready),   32'(q_data.size() < DEPTH));
        chk("out_valid",  32'(out_valid),  32'(q_data.size() > 0));
        chk("out_data",   out_data,        (q_data.size() > 0) ? q_data[0] : m_hold_data);
        chk("out_last",   32'(out_last),   32'((q_data.size() > 0) ? q_last[0] : m_hold_last));
        chk("conv_count", 32'(conv_count), 32'(m_count));
    endtask

    // Drive one cycle starting just after a rising edge; ends 1 time unit
    // after the next rising edge with the model updated.
    task automatic cycle(input logic v, input logic [31:0] d, input logic l,
                         input logic [1:0] m, input logic ordy, input logic clr);
        logic        acc, drn;
        logic [31:0] nd;
        int          n;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        mode      = m;
        out_ready = ordy;
        cnt_clr   = clr;
        #1;
        check_all();
        acc = v && (q_data.size() < DEPTH);
        drn = ordy && (q_data.size() > 0);
        nd  = conv_beat(d, m);
        n   = n_diff(nd, d);
        @(posedge clk);
        #1;
        if (drn) begin
            void'(q_data.pop_front());
            void'(q_last.pop_front());
        end
        if (acc) begin
            q_data.push_back(nd);
            q_last.push_back(l);
        end
        if (clr)      m_count = acc ? ((n > CMAX) ? CMAX : n) : 0;
        else if (acc) m_count = (m_count + n > CMAX) ? CMAX : m_count + n;
        if (q_data.size() > 0) begin
            m_hold_data = q_data[0];
            m_hold_last = q_last[0];
        end
    endtask

    initial begin
        in_valid = 0; in_data = '0; in_last = 0; mode = 0; out_ready = 0; cnt_clr = 0;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_out_valid",  32'(out_valid),  32'd0);
        chk("rst_out_data",   out_data,        32'd0);
        chk("rst_out_last",   32'(out_last),   32'd0);
        chk("rst_conv_count", 32'(conv_count), 32'd0);
        chk("rst_in_ready",   32'(in_ready),   32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Upper conversion, next-cycle output
        cycle(0, 32'h0, 0, 2'd0, 1, 1);
        cycle(1, 32'h7A615B41, 0, 2'd1, 1, 0);
        chk("t1_data",  out_data, 32'h5A415B41);
        chk("t1_count", 32'(conv_count), 32'd2);

        // Lower, toggle, pass
        cycle(1, 32'h40415A5B, 1, 2'd2, 1, 0);
        chk("t2_lower", out_data, 32'h40617A5B);
        chk("t2_last",  32'(out_last), 32'd1);
        chk("t2_cnt_a", 32'(conv_count), 32'd4);
        cycle(1, 32'h614131E1, 0, 2'd3, 1, 0);
        chk("t2_toggle", out_data, 32'h416131E1);
        chk("t2_cnt_b",  32'(conv_count), 32'd6);
        cycle(1, 32'h61414243, 0, 2'd0, 1, 0);
        chk("t2_pass",   out_data, 32'h61414243);
        chk("t2_cnt_c",  32'(conv_count), 32'd6);

        // Mode switches every cycle
        cycle(1, 32'h61616161, 0, 2'd1, 1, 1);
        chk("t4_upper", out_data, 32'h41414141);
        chk("t4_cnt",   32'(conv_count), 32'd4);
        cycle(1, 32'h61616161, 0, 2'd2, 1, 0);
        chk("t4_lower", out_data, 32'h61616161);
        cycle(1, 32'h61616161, 0, 2'd3, 1, 0);
        chk("t4_toggle", out_data, 32'h41414141);
        chk("t4_cnt2",   32'(conv_count), 32'd8);
        cycle(0, 32'h0, 0, 2'd0, 1, 0);

        // Backpressure with a full buffer
        cycle(1, 32'h31323334, 1, 2'd0, 0, 0);
        cycle(1, 32'h41424344, 0, 2'd0, 0, 0);
        chk("t3_full",  32'(in_ready), 32'd0);
        chk("t3_hold1", out_data, 32'h31323334);
        cycle(1, 32'h35363738, 1, 2'd0, 0, 0);
        chk("t3_hold2", out_data, 32'h31323334);
        chk("t3_valid", 32'(out_valid), 32'd1);
        cycle(1, 32'h35363738, 1, 2'd0, 1, 0);
        chk("t3_beat2",  out_data, 32'h41424344);
        chk("t3_last2",  32'(out_last), 32'd0);
        cycle(1, 32'h35363738, 1, 2'd0, 1, 0);
        chk("t3_beat3",  out_data, 32'h35363738);
        chk("t3_last3",  32'(out_last), 32'd1);
        cycle(0, 32'h0, 0, 2'd0, 1, 0);
        chk("t3_empty",  32'(out_valid), 32'd0);
        chk("t3_keep",   out_data, 32'h35363738);

        // Saturation and clear-with-accept
        cycle(0, 32'h0, 0, 2'd0, 1, 1);
        for (int i = 0; i < 4; i++) cycle(1, 32'h61626364, 0, 2'd1, 1, 0);
        chk("t5_sat", 32'(conv_count), 32'd15);
        cycle(1, 32'h61623132, 0, 2'd1, 1, 1);
        chk("t5_clr", 32'(conv_count), 32'd2);
        cycle(0, 32'h0, 0, 2'd0, 1, 1);
        chk("t5_clr_only", 32'(conv_count), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] d;
            for (int k = 0; k < LANES; k++) d[8*k +: 8] = rand_byte();
            cycle(($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 4) > 1),
                  ($urandom_range(0, 7) == 0));
        end

        // Reset with beats buffered
        cycle(0, 32'h0, 0, 2'd0, 1, 0);
        cycle(0, 32'h0, 0, 2'd0, 1, 0);
        cycle(1, 32'h61616161, 0, 2'd1, 0, 0);
        cycle(1, 32'h62626262, 1, 2'd1, 0, 0);
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_valid", 32'(out_valid),  32'd0);
        chk("t6_count", 32'(conv_count), 32'd0);
        chk("t6_ready", 32'(in_ready),   32'd1);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(1, 32'h7A7A7A7A, 0, 2'd1, 0, 0);
        chk("t6_first", out_data, 32'h5A5A5A5A);
        chk("t6_fvalid", 32'(out_valid), 32'd1);
        cycle(0, 32'h0, 0, 2'd0, 1, 0);
        cycle(0, 32'h0, 0, 2'd0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
